instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 64, maximum words written per session (1..255).
REQ-003 Clock and reset: one clock and an asynchronous, active-high reset; ports named clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-high reset.
REQ-006 start  in  1  begin load session; sampled in IDLE only.
REQ-007 in_valid  in  1  instruction fields valid.
REQ-008 in_ready  out  1  encoder can accept fields.
REQ-009 fmt  in  2  00=R, 01=I, 10=J, 11=illegal.
REQ-010 op, funct  in  6 each; rs, rt, rd, shamt  in  5 each; imm  in  16; target  in  26; instruction fields.
REQ-011 last  in  1  marks final instruction of session.
REQ-012 imem_we  out  1  instruction-memory write strobe.
REQ-013 imem_addr  out  32  word-aligned byte address.
REQ-014 imem_wd  out  32  encoded instruction word.
REQ-015 busy  out  1  session active; done  out  1  one-cycle end pulse; count  out  8  words written.
REQ-016 err_fmt  out  1  sticky illegal-format flag; err_ovf  out  1  sticky overflow flag.
REQ-017 checksum  out  32  running XOR of written words (see Configuration).

Function
REQ-018 FSM states IDLE, ACCEPT, WRITE, DONE.
REQ-019 IDLE: start=1 -> ACCEPT next cycle; count, err_fmt, err_ovf, checksum cleared; address pointer loaded with BASE_ADDR.
REQ-020 in_ready SHALL be 1 only in ACCEPT; handshake = in_valid & in_ready.
REQ-021 Handshake with fmt=R SHALL register word {op,rs,rt,rd,shamt,funct}; fmt=I {op,rs,rt,imm}; fmt=J {op,target}; then -> WRITE.
REQ-022 Handshake with fmt=11 SHALL drop the instruction, set err_fmt, write nothing, stay in ACCEPT; if last=1, -> DONE instead.
REQ-023 WRITE: imem_we=1 for exactly one cycle, imem_wd = registered word, imem_addr = pointer; latency handshake -> imem_we is exactly 1 cycle.
REQ-024 At end of WRITE, pointer += 4, count += 1; next state DONE if registered last=1 or new count==MAX_WORDS, else ACCEPT.
REQ-025 count reaching MAX_WORDS without last SHALL set err_ovf; last on the MAX_WORDS-th word SHALL NOT set err_ovf.
REQ-026 DONE: done=1 for one cycle, -> IDLE; busy=1 in ACCEPT, WRITE, DONE.
REQ-027 start outside IDLE SHALL be ignored; in_valid outside ACCEPT SHALL be ignored.
REQ-028 imem_addr, count, err flags, checksum SHALL hold their values in IDLE after a session until the next start.
REQ-029 imem_we SHALL be 0 in every state except WRITE; throughput one word per two cycles.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, imem_we=0, in_ready=0, busy=0, done=0, count=0, err_fmt=0, err_ovf=0, checksum=0, imem_wd=0, imem_addr=BASE_ADDR.
REQ-031 reset during WRITE SHALL abort the write (imem_we drops asynchronously); no partial session resumes after release.

Configuration
REQ-032 Macro ENC_CHECKSUM_EN defined: checksum SHALL update to checksum XOR imem_wd at each WRITE cycle.
REQ-033 Macro ENC_CHECKSUM_EN undefined: checksum SHALL be constant 0 and no checksum register exists.

Verification
REQ-034 start; R op=0 rs=9 rt=10 rd=8 shamt=0 funct=0x20 last=1 -> imem_we one cycle, addr=BASE_ADDR, wd=0x012A4020, done next cycle, count=1.
REQ-035 I op=0x23 rs=0 rt=2 imm=0x0050, then J op=2 target=0x0000011 last=1 -> wd 0x8C020050 @0x0, 0x08000011 @0x4; checksum=0x84020041 with ENC_CHECKSUM_EN, 0 without.
REQ-036 fmt=11 mid-session then R word with last=1 -> err_fmt=1, only one write, count=1.
REQ-037 MAX_WORDS=2, three instructions offered, none last -> two writes @0x0,0x4, err_ovf=1, done, third never accepted (in_ready=0).
REQ-038 reset asserted during WRITE of second word -> imem_we falls same cycle, all outputs at reset values, FSM IDLE; new start restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs R/I/J instruction fields into 32-bit words and writes them to instruction memory
// Optional running XOR checksum of written words is built when ENC_CHECKSUM_EN is defined.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        busy,
  output logic        done,
  output logic [7:0]  count,
  output logic        err_fmt,
  output logic        err_ovf,
  output logic [31:0] checksum
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  count_q, count_d;
  logic        last_q, last_d;
  logic        err_fmt_q, err_fmt_d;
  logic        err_ovf_q, err_ovf_d;
  logic [31:0] enc_word;
  logic [7:0]  count_inc;

  always_comb begin
    enc_word = 32'h0;
    case (fmt)
      2'b00:   enc_word = {op, rs, rt, rd, shamt, funct};
      2'b01:   enc_word = {op, rs, rt, imm};
      2'b10:   enc_word = {op, target};
      default: enc_word = 32'h0;
    endcase
  end

  assign count_inc = count_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    count_d   = count_q;
    last_d    = last_q;
    err_fmt_d = err_fmt_q;
    err_ovf_d = err_ovf_q;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACCEPT;
          addr_d    = BASE_ADDR;
          count_d   = 8'd0;
          err_fmt_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (fmt == 2'b11) begin
            // Illegal format is dropped; a final illegal word still closes the session.
            err_fmt_d = 1'b1;
            if (last) state_d = S_DONE;
          end else begin
            word_d  = enc_word;
            last_d  = last;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        addr_d  = addr_q + 32'd4;
        count_d = count_inc;
        if (last_q) begin
          state_d = S_DONE;
        end else if (count_inc == MAX_CNT) begin
          err_ovf_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= BASE_ADDR;
      word_q    <= 32'h0;
      count_q   <= 8'd0;
      last_q    <= 1'b0;
      err_fmt_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      count_q   <= count_d;
      last_q    <= last_d;
      err_fmt_q <= err_fmt_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign imem_addr = addr_q;
  assign imem_wd   = word_q;
  assign count     = count_q;
  assign err_fmt   = err_fmt_q;
  assign err_ovf   = err_ovf_q;

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == S_IDLE && start) begin
      csum_d = 32'h0;
    end else if (state_q == S_WRITE) begin
      csum_d = csum_q ^ word_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= 32'h0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized bench for instr_encoder against an event-level reference model
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  fmt = 2'b00;
  logic [5:0]  op = 6'h0, funct = 6'h0;
  logic [4:0]  rs = 5'h0, rt = 5'h0, rd = 5'h0, shamt = 5'h0;
  logic [15:0] imm = 16'h0;
  logic [25:0] target = 26'h0;
  logic        last = 1'b0;

  logic        in_ready, imem_we, busy, done, err_fmt, err_ovf;
  logic [31:0] imem_addr, imem_wd, checksum;
  logic [7:0]  count;

  logic        d2_in_ready, d2_we, d2_busy, d2_done, d2_err_fmt, d2_err_ovf;
  logic [31:0] d2_addr, d2_wd, d2_checksum;
  logic [7:0]  d2_count;

  instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target), .last(last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wd(imem_wd), .busy(busy), .done(done), .count(count), .err_fmt(err_fmt),
    .err_ovf(err_ovf), .checksum(checksum)
  );

  instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(d2_in_ready),
    .fmt(fmt), .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target), .last(last), .imem_we(d2_we), .imem_addr(d2_addr),
    .imem_wd(d2_wd), .busy(d2_busy), .done(d2_done), .count(d2_count), .err_fmt(d2_err_fmt),
    .err_ovf(d2_err_ovf), .checksum(d2_checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                         input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
    logic [31:0] w;
    w = 32'h0;
    if (f == 2'd0) w = (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
    if (f == 2'd1) w = (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
    if (f == 2'd2) w = (32'(o) << 26) | 32'(tg);
    return w;
  endfunction

  // Reference model: expected outputs for the cycle seen at the next falling edge.
  bit          m_busy, m_ready, m_we, m_done, m_efmt, m_eovf, m_plast;
  int          m_cnt;
  logic [31:0] m_word, m_csum;
  logic [31:0] wa_q[$], wd_q[$], wa2_q[$];
  int          dones, d2_dones;

  always @(negedge clk) begin
    logic [31:0] exp_cs;
    if (reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_err_fmt", err_fmt, 0);
      chk("rst_err_ovf", err_ovf, 0);
      chk("rst_checksum", checksum, 0);
      chk("rst_wd", imem_wd, 0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_d2_we", d2_we, 0);
      m_busy = 0; m_ready = 0; m_we = 0; m_done = 0; m_efmt = 0; m_eovf = 0; m_plast = 0;
      m_cnt = 0; m_word = 32'h0; m_csum = 32'h0;
    end else begin
`ifdef ENC_CHECKSUM_EN
      exp_cs = m_csum;
`else
      exp_cs = 32'h0;
`endif
      chk("in_ready", in_ready, m_ready);
      chk("busy", busy, m_busy);
      chk("imem_we", imem_we, m_we);
      chk("done", done, m_done);
      chk("count", count, m_cnt);
      chk("err_fmt", err_fmt, m_efmt);
      chk("err_ovf", err_ovf, m_eovf);
      chk("imem_addr", imem_addr, BASE + 32'(4 * m_cnt));
      chk("imem_wd", imem_wd, m_word);
      chk("checksum", checksum, exp_cs);
      if (imem_we) begin wa_q.push_back(imem_addr); wd_q.push_back(imem_wd); end
      if (done) dones++;
      if (d2_we) wa2_q.push_back(d2_addr);
      if (d2_done) d2_dones++;

      if (m_we) begin
        m_we = 0;
        m_cnt++;
        m_csum ^= m_word;
        if (m_plast || m_cnt == MAXW) begin
          if (!m_plast) m_eovf = 1;
          m_done = 1;
        end else begin
          m_ready = 1;
        end
      end else if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_ready) begin
        if (in_valid) begin
          if (fmt != 2'b11) begin
            m_word = encode(fmt, op, rs, rt, rd, shamt, funct, imm, target);
            m_plast = last;
            m_we = 1;
            m_ready = 0;
          end else begin
            m_efmt = 1;
            if (last) begin m_done = 1; m_ready = 0; end
          end
        end
      end else if (!m_busy && start) begin
        m_cnt = 0; m_efmt = 0; m_eovf = 0; m_csum = 32'h0;
        m_busy = 1; m_ready = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_fields();
    op = 6'($urandom); funct = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); shamt = 5'($urandom); imm = 16'($urandom); target = 26'($urandom);
  endtask

  task automatic start_session();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic offer(input logic l, input bit spam, output bit d2_seen);
    bit hs;
    last = l;
    in_valid = 1'b1;
    d2_seen = 0;
    for (int n = 0; n < 40; n++) begin
      hs = in_ready;
      if (d2_in_ready) d2_seen = 1;
      if (spam) start = ($urandom_range(0, 3) == 0);
      tick();
      if (hs) begin
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL offer_timeout: in_ready never seen, required 1 at %0t", $time);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20; n++) begin
      if (!busy) return;
      tick();
    end
    n_cmp++; n_bad++;
    $display("FAIL idle_timeout: busy stuck at 1, required 0 at %0t", $time);
  endtask

  task automatic set_r_add();
    rand_fields();
    fmt = 2'd0; op = 6'd0; rs = 5'd9; rt = 5'd10; rd = 5'd8; shamt = 5'd0; funct = 6'h20;
  endtask

  initial begin
    bit seen;
    int n, legal, d0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single R-type word with last.
    wa_q.delete(); wd_q.delete(); d0 = dones;
    start_session();
    set_r_add();
    offer(1'b1, 0, seen);
    wait_idle();
    chk("t1_nwr", wa_q.size(), 1);
    chk("t1_addr", wa_q[0], 32'h0);
    chk("t1_wd", wd_q[0], 32'h012A4020);
    chk("t1_count", count, 1);
    chk("t1_dones", dones - d0, 1);

    // I then J, last on the second word; dut2 hits MAX on the last word without overflow.
    wa_q.delete(); wd_q.delete();
    start_session();
    rand_fields(); fmt = 2'd1; op = 6'h23; rs = 5'd0; rt = 5'd2; imm = 16'h0050;
    offer(1'b0, 0, seen);
    rand_fields(); fmt = 2'd2; op = 6'd2; target = 26'h0000011;
    offer(1'b1, 0, seen);
    wait_idle();
    chk("t2_nwr", wa_q.size(), 2);
    chk("t2_addr0", wa_q[0], 32'h0);
    chk("t2_wd0", wd_q[0], 32'h8C020050);
    chk("t2_addr1", wa_q[1], 32'h4);
    chk("t2_wd1", wd_q[1], 32'h08000011);
    chk("t2_count", count, 2);
`ifdef ENC_CHECKSUM_EN
    chk("t2_checksum", checksum, 32'h84020041);
`else
    chk("t2_checksum", checksum, 32'h0);
`endif
    chk("t2_d2_count", d2_count, 2);
    chk("t2_d2_ovf", d2_err_ovf, 0);

    // Illegal format mid-session, then R with last.
    wa_q.delete(); wd_q.delete();
    start_session();
    rand_fields(); fmt = 2'd3;
    offer(1'b0, 0, seen);
    set_r_add();
    offer(1'b1, 0, seen);
    wait_idle();
    chk("t3_err_fmt", err_fmt, 1);
    chk("t3_nwr", wa_q.size(), 1);
    chk("t3_wd", wd_q[0], 32'h012A4020);
    chk("t3_count", count, 1);
    chk("t3_err_ovf", err_ovf, 0);

    // Overflow on dut2 (MAX_WORDS=2): third instruction must not be accepted there.
    wa2_q.delete(); d0 = d2_dones;
    start_session();
    for (int i = 0; i < 3; i++) begin
      rand_fields(); fmt = 2'($urandom_range(0, 2));
      offer(1'b0, 0, seen);
    end
    chk("t4_d2_ready_on_third", seen, 0);
    rand_fields(); fmt = 2'd1;
    offer(1'b1, 0, seen);
    wait_idle();
    chk("t4_d2_nwr", wa2_q.size(), 2);
    chk("t4_d2_addr0", wa2_q[0], 32'h0);
    chk("t4_d2_addr1", wa2_q[1], 32'h4);
    chk("t4_d2_ovf", d2_err_ovf, 1);
    chk("t4_d2_count", d2_count, 2);
    chk("t4_d2_dones", d2_dones - d0, 1);
    chk("t4_main_count", count, 4);
    chk("t4_main_ovf", err_ovf, 0);

    // Reset during the second word's WRITE cycle, then a fresh session.
    start_session();
    set_r_add();
    offer(1'b0, 0, seen);
    rand_fields(); fmt = 2'd1;
    offer(1'b0, 0, seen);
    chk("t5_we_before", imem_we, 1);
    reset = 1'b1;
    #1;
    chk("t5_we_async", imem_we, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_count_async", count, 0);
    chk("t5_addr_async", imem_addr, BASE);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_idle_ready", in_ready, 0);
    wa_q.delete(); wd_q.delete();
    start_session();
    set_r_add();
    offer(1'b1, 0, seen);
    wait_idle();
    chk("t5_nwr", wa_q.size(), 1);
    chk("t5_addr", wa_q[0], BASE);

    // Randomized sessions with ignored start/in_valid outside their windows.
    for (int s = 0; s < 60; s++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        in_valid = 1'($urandom); rand_fields(); fmt = 2'($urandom); last = 1'($urandom);
        tick();
      end
      start_session();
      n = $urandom_range(1, 9);
      legal = 0;
      for (int i = 0; i < n; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        rand_fields();
        fmt = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        offer(i == n - 1, 1, seen);
        if (fmt != 2'd3) legal++;
        if (legal == MAXW) break;
      end
      wait_idle();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
